// File: rtl/bkm_stim_pkg.sv
// ============================================================================
// Module   : bkm_stim_pkg
// Brief    : Shared types and constants for the BKM stimulus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bkm_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GEN    = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] C_LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] C_DEFAULT_SEED = 32'hACE1_0001;

    function automatic int cnt_width(input int n_tests);
        return $clog2(n_tests + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bkm_lfsr32.sv
// ============================================================================
// Module   : bkm_lfsr32
// Brief    : 32-bit right-shifting Galois LFSR with look-ahead next value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bkm_lfsr32
    import bkm_stim_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        enable,
    input  logic        advance,
    input  logic [31:0] seed,
    output logic [31:0] value,
    output logic [31:0] next_value
);

    logic [31:0] r_value;

    always_comb begin
        next_value = (r_value >> 1) ^ (r_value[0] ? C_LFSR_TAPS : 32'h0);
    end

    // An all-zero state would lock up the register, so a zero seed becomes 1
    always_ff @(posedge clk) begin
        if (srst) begin
            r_value <= (seed == 32'h0) ? 32'h1 : seed;
        end else if (enable && advance) begin
            r_value <= next_value;
        end
    end

    assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/bkm_stim_gen.sv
// ============================================================================
// Module   : bkm_stim_gen
// Brief    : Stimulus sequencer issuing LFSR operand pairs to a BKM-step DUT.
//            Optional WAIT timeout enabled by defining BKM_STIM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bkm_stim_gen
    import bkm_stim_pkg::*;
#(
    parameter int          DATA_W  = 16,
    parameter int          N_TESTS = 1024,
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] SEED    = C_DEFAULT_SEED,
    localparam int         CNT_W   = cnt_width(N_TESTS)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              enable,
    input  logic              run,
    input  logic              done,
    output logic              start,
    output logic              check,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out,
    output logic [CNT_W-1:0]  test_cnt,
    output logic              busy,
    output logic              finished,
    output logic              timeout_err
);

    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_x;
    logic [DATA_W-1:0]  r_y;
    logic [CNT_W-1:0]   r_test_cnt;
    logic [31:0]        w_lfsr_next;
    logic [31:0]        w_unused_lfsr_value;
    logic               w_last_vector;
    logic               w_timeout_hit;

    bkm_lfsr32 u_lfsr (
        .clk        (clk),
        .srst       (srst),
        .enable     (enable),
        .advance    (r_state == ST_GEN),
        .seed       (SEED),
        .value      (w_unused_lfsr_value),
        .next_value (w_lfsr_next)
    );

    assign w_last_vector = (r_test_cnt == CNT_W'(N_TESTS - 1));

`ifdef BKM_STIM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout_err;

    assign w_timeout_hit = (r_wait_cnt == WAIT_W'(TIMEOUT - 1));

    // START is the only way into WAIT, so clearing there gives a fresh count
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else if (enable) begin
            if (r_state == ST_START) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (r_state == ST_WAIT && !done && w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end else if (r_state == ST_FINISH && run) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout_hit = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (enable) begin
            case (r_state)
                ST_IDLE:   if (run) w_state_next = ST_GEN;
                ST_GEN:    w_state_next = ST_START;
                ST_START:  w_state_next = ST_WAIT;
                ST_WAIT: begin
                    // done takes priority over a coincident timeout
                    if (done) begin
                        w_state_next = ST_CHECK;
                    end else if (w_timeout_hit) begin
                        w_state_next = ST_FINISH;
                    end
                end
                ST_CHECK:  w_state_next = w_last_vector ? ST_FINISH : ST_GEN;
                ST_FINISH: if (run) w_state_next = ST_GEN;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        start    = enable && (r_state == ST_START);
        check    = enable && (r_state == ST_CHECK);
        busy     = (r_state == ST_GEN) || (r_state == ST_START) ||
                   (r_state == ST_WAIT) || (r_state == ST_CHECK);
        finished = (r_state == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_test_cnt <= '0;
        end else if (enable) begin
            if (r_state == ST_GEN) begin
                r_x <= w_lfsr_next[DATA_W-1:0];
                r_y <= w_lfsr_next[31 -: DATA_W];
            end
            if (r_state == ST_CHECK) begin
                r_test_cnt <= r_test_cnt + CNT_W'(1);
            end else if (r_state == ST_FINISH && run) begin
                r_test_cnt <= '0;
            end
        end
    end

    assign x_out    = r_x;
    assign y_out    = r_y;
    assign test_cnt = r_test_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bkm_stim_gen.sv
// ============================================================================
// Module   : tb_bkm_stim_gen
// Brief    : Directed self-checking bench for bkm_stim_gen (SEED=1, N_TESTS=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bkm_stim_gen;

    logic        clk = 1'b0;
    logic        srst;
    logic        enable;
    logic        run;
    logic        done;
    logic        start;
    logic        check;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic [1:0]  test_cnt;
    logic        busy;
    logic        finished;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int n_check = 0;
    int chk_before;

    bkm_stim_gen #(
        .DATA_W  (16),
        .N_TESTS (3),
        .TIMEOUT (8),
        .SEED    (32'h0000_0001)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .enable      (enable),
        .run         (run),
        .done        (done),
        .start       (start),
        .check       (check),
        .x_out       (x_out),
        .y_out       (y_out),
        .test_cnt    (test_cnt),
        .busy        (busy),
        .finished    (finished),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start === 1'b1) n_start++;
        if (check === 1'b1) n_check++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered in GEN; leaves in the state after CHECK. done pulses once in START
    // (must be ignored) and again on the second WAIT cycle.
    task automatic vector(input logic [15:0] ex, input logic [15:0] ey, input int cnt_before);
        chk("gen_busy", busy, 1);
        tick();
        chk("start_pulse", start, 1);
        chk("x_first", x_out, ex);
        chk("y_first", y_out, ey);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("no_check_in_wait", check, 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("check_pulse", check, 1);
        chk("cnt_in_check", test_cnt, cnt_before);
        chk("x_hold", x_out, ex);
        chk("y_hold", y_out, ey);
        tick();
        chk("cnt_after", test_cnt, cnt_before + 1);
    endtask

    initial begin
        srst = 1'b1; enable = 1'b1; run = 1'b0; done = 1'b0;
        repeat (3) tick();
        srst = 1'b0;
        chk("rst_start", start, 0);
        chk("rst_check", check, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_cnt", test_cnt, 0);
        chk("rst_terr", timeout_err, 0);

        // Campaign 1: LFSR steps 1..3 from seed 1
        run = 1'b1;
        tick();
        run = 1'b0;
        vector(16'h0003, 16'h8020, 0);
        vector(16'h0002, 16'hC030, 1);
        vector(16'h0001, 16'h6018, 2);
        chk("c1_finished", finished, 1);
        chk("c1_busy", busy, 0);
        chk("c1_cnt", test_cnt, 3);
        chk("c1_terr", timeout_err, 0);
        chk("c1_starts", n_start, 3);
        chk("c1_checks", n_check, 3);

        // Campaign 2 restarts from FINISH with a 5-cycle enable freeze in WAIT
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("c2_cnt_cleared", test_cnt, 0);
        chk("c2_not_finished", finished, 0);
        tick();
        chk("c2_start", start, 1);
        chk("c2_x_step4", x_out, 16'h0003);
        chk("c2_y_step4", y_out, 16'hB02C);
        tick();
        enable = 1'b0;
        done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("frz_busy", busy, 1);
            chk("frz_start", start, 0);
            chk("frz_check", check, 0);
            chk("frz_x", x_out, 16'h0003);
            chk("frz_cnt", test_cnt, 0);
        end
        done = 1'b0;
        enable = 1'b1;
        tick();
        chk("post_frz_wait", check, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("c2_check", check, 1);
        tick();
        chk("c2_cnt1", test_cnt, 1);
        vector(16'h0002, 16'hD836, 1);
        vector(16'h0001, 16'h6C1B, 2);
        chk("c2_finished", finished, 1);
        chk("c2_cnt", test_cnt, 3);
        chk("c2_starts", n_start, 6);
        chk("c2_checks", n_check, 6);

        // Campaign 3: reset in WAIT of vector 2
        run = 1'b1;
        tick();
        run = 1'b0;
        vector(16'h8003, 16'hB62D, 0);
        tick();
        chk("c3_x_step8", x_out, 16'hC002);
        chk("c3_y_step8", y_out, 16'hDB36);
        tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_finished", finished, 0);
        chk("mid_rst_cnt", test_cnt, 0);
        chk("mid_rst_x", x_out, 0);
        chk("mid_rst_y", y_out, 0);
        run = 1'b1;
        tick();
        run = 1'b0;
        vector(16'h0003, 16'h8020, 0);

`ifdef BKM_STIM_TIMEOUT_EN
        srst = 1'b1;
        tick();
        srst = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        chk_before = n_check;
        repeat (7) tick();
        chk("to_still_wait", busy, 1);
        chk("to_not_finished", finished, 0);
        tick();
        chk("to_finished", finished, 1);
        chk("to_err", timeout_err, 1);
        chk("to_cnt", test_cnt, 0);
        chk("to_no_check", n_check, chk_before);

        run = 1'b1;
        tick();
        run = 1'b0;
        chk("to_err_cleared", timeout_err, 0);
        tick();
        tick();
        repeat (7) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("to_edge_check", check, 1);
        chk("to_edge_err", timeout_err, 0);
        tick();
        chk("to_edge_cnt", test_cnt, 1);
`else
        srst = 1'b1;
        tick();
        srst = 1'b0;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        repeat (20) tick();
        chk("nto_busy", busy, 1);
        chk("nto_finished", finished, 0);
        chk("nto_err", timeout_err, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("nto_check", check, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bkm_stim_gen.md
# bkm_stim_gen

Stimulus sequencer for the BKM-step verification bench. It generates pseudo-random operand pairs from an LFSR and issues one `start` per test vector to the DUT. It waits for the DUT's `done`, then emits a one-cycle `check` strobe that drives the result checker's `done`/`enable` inputs. It counts completed vectors and, optionally, flags a DUT that never answers.

## Interface
Parameters:
- `DATA_W`, 16: operand width; legal range 1..16.
- `N_TESTS`, 1024: number of vectors per campaign; must be ≥1.
- `TIMEOUT`, 64: maximum cycles spent in WAIT before timeout; must be ≥2.
- `SEED`, 32'hACE1_0001: LFSR reset value; a zero seed is replaced by 32'h1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `srst`  in  1  synchronous, active-high reset.
- `enable`  in  1  global advance qualifier; when low, every register holds.
- `run`  in  1  campaign start request; sampled only in IDLE and FINISH.
- `done`  in  1  DUT completion; sampled only in WAIT.
- `start`  out  1  one-cycle request to the DUT.
- `check`  out  1  one-cycle strobe to the checker; operands and DUT result are valid.
- `x_out`  out  DATA_W  operand X.
- `y_out`  out  DATA_W  operand Y.
- `test_cnt`  out  CNT_W = $clog2(N_TESTS+1)  completed-vector count.
- `busy`  out  1  high in GEN/START/WAIT/CHECK.
- `finished`  out  1  high in FINISH.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, GEN, START, WAIT, CHECK, FINISH.
  - IDLE --run--> GEN.
  - GEN --> START.
  - START --> WAIT.
  - WAIT --done--> CHECK.
  - CHECK --> FINISH if the incremented `test_cnt` == N_TESTS, else GEN.
  - FINISH --run--> GEN.
- Every transition and register update is qualified by `enable`. With `enable` low, state, LFSR, counters and operands hold.
- `start` and `check` are combinational decodes: `start` = (state==START)&enable, `check` = (state==CHECK)&enable. Each is therefore exactly one enabled cycle wide.
- LFSR: 32-bit Galois, taps 32'h8020_0003 (x^32+x^22+x^2+x+1), shifts right. It advances once per enabled GEN cycle.
- In GEN, `x_out` <= next_lfsr[DATA_W-1:0] and `y_out` <= next_lfsr[31 -: DATA_W]. Both hold stable from START through CHECK.
- `test_cnt` increments at the end of each enabled CHECK cycle.
- Leaving FINISH on `run` clears `test_cnt` and `timeout_err`. The LFSR is not reseeded, so a new campaign produces new vectors.
- `done` outside WAIT is ignored, including `done` coincident with `start`.
- `srst` overrides everything, including mid-campaign: state=IDLE, lfsr=SEED (or 1), `x_out`=`y_out`=0, `test_cnt`=0, `timeout_err`=0. After reset, `start`=`check`=`busy`=`finished`=0.

## Timing
- `run` high in IDLE at cycle 0: GEN at 1, START at 2 (`start`=1, operands valid), WAIT from 3.
- `done` seen in WAIT at cycle k: CHECK at k+1 (`check`=1), next GEN at k+2.
- Minimum period per vector is 4 cycles (GEN, START, WAIT with immediate `done`, CHECK).
- `finished` rises the cycle after the last CHECK.
- Wait counter clears on WAIT entry and increments each enabled WAIT cycle.

## Configuration
- `BKM_STIM_TIMEOUT_EN` defined:
  - If the wait counter reaches TIMEOUT-1 without `done`, the FSM goes to FINISH and `timeout_err` is set.
  - `check` is not pulsed and `test_cnt` is unchanged.
  - `done` on the same cycle as the timeout wins: the FSM goes to CHECK and the error is not set.
- Not defined: no wait counter; WAIT waits indefinitely; `timeout_err` is tied 0.

## Structure
- Shared package `bkm_stim_pkg` holds:
  - the state enum;
  - the LFSR tap constant 32'h8020_0003;
  - the default seed;
  - the CNT_W computation function.
- One sub-module, `bkm_lfsr32`, with ports clk, srst, enable, advance, seed, value and next_value.

## Test plan
- SEED=1, DATA_W=16, N_TESTS=3, DUT answers `done` 2 cycles after `start` -> 3 `start` pulses and 3 `check` pulses; first `x_out`=16'h0003, `y_out`=16'h8020; `test_cnt`=3; `finished`=1; `timeout_err`=0.
- Same setup with `enable` low for 5 cycles during WAIT -> all outputs frozen, no extra pulses, final counts unchanged.
- `BKM_STIM_TIMEOUT_EN`, TIMEOUT=8, `done` never asserted -> FINISH 8 cycles after WAIT entry, `timeout_err`=1, `test_cnt`=0, no `check` pulse.
- `done` asserted on the exact timeout cycle -> `check` pulses, `test_cnt`=1, `timeout_err`=0.
- `srst` asserted in WAIT of vector 2 -> next cycle IDLE, `test_cnt`=0, `x_out`=0; a following `run` reproduces the vector-1 operands (16'h0003/16'h8020).
- `run` in FINISH -> `test_cnt` clears; new first operand equals the 4th LFSR step value.
